// File: rtl/mac_accum_seq.sv
// mac_accum_seq: counted add/sub accumulator with wrap or saturate overflow and a valid/ready result port.
module mac_accum_seq #(
  parameter int W     = 16,
  parameter int LEN_W = 8,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     acc_out,
  output logic             ovf,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t state;
  logic [W-1:0] acc;
  logic [LEN_W-1:0] count;
  logic [W-1:0] sum;
  logic [W-1:0] nxt;
  logic o_v;
  always_comb begin
    sum = in_sub ? acc - in_data : acc + in_data;
    o_v = (in_sub ? acc[W-1] != in_data[W-1] : acc[W-1] == in_data[W-1]) && (sum[W-1] != acc[W-1]);
    // overflow direction follows the accumulator's sign
    nxt = (SAT && o_v) ? (acc[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : sum;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      ovf       <= 1'b0;
      acc_out   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc   <= '0;
          ovf   <= 1'b0;
          count <= len;
          busy  <= 1'b1;
          if (len != '0) begin
            state    <= ACC;
            in_ready <= 1'b1;
          end else begin
            state     <= DONE;
            out_valid <= 1'b1;
            acc_out   <= '0;
          end
        end
        ACC: if (in_valid) begin
          acc   <= nxt;
          ovf   <= ovf | o_v;
          count <= count - LEN_W'(1);
          if (count == LEN_W'(1)) begin
            state     <= DONE;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
            acc_out   <= nxt;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_accum_seq.sv
// tb_mac_accum_seq: wrap and saturate instances driven in lockstep, results checked by a queue-based scoreboard.
module tb_mac_accum_seq;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0, in_sub = 0, out_ready = 0;
  logic [7:0] len = 0;
  logic [15:0] in_data = 0;
  logic in_ready[2], out_valid[2], ovf[2], busy[2];
  logic [15:0] acc_out[2];
  int checks = 0, errors = 0;
  logic [16:0] exp0[$], exp1[$];
  logic [15:0] d_q[$];
  bit s_q[$];
  logic pv[2];
  logic [15:0] pa[2];

  mac_accum_seq #(.W(16), .LEN_W(8), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_data(in_data), .in_sub(in_sub), .out_valid(out_valid[0]), .out_ready(out_ready),
    .acc_out(acc_out[0]), .ovf(ovf[0]), .busy(busy[0]));
  mac_accum_seq #(.W(16), .LEN_W(8), .SAT(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_data(in_data), .in_sub(in_sub), .out_valid(out_valid[1]), .out_ready(out_ready),
    .acc_out(acc_out[1]), .ovf(ovf[1]), .busy(busy[1]));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] model(input bit sat);
    int a = 0;
    bit o = 0;
    foreach (d_q[i]) begin
      int d = $signed(d_q[i]);
      int r = s_q[i] ? a - d : a + d;
      if (r > 32767) begin
        o = 1;
        r = sat ? 32767 : r - 65536;
      end else if (r < -32768) begin
        o = 1;
        r = sat ? -32768 : r + 65536;
      end
      a = r;
    end
    return {o, a[15:0]};
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [16:0] e;
      if (rst_n && pv[k]) begin
        chk($sformatf("hold_valid%0d", k), int'(out_valid[k]), 1);
        chk($sformatf("hold_acc%0d", k), int'(acc_out[k]), int'(pa[k]));
      end
      if (rst_n && out_valid[k] && out_ready) begin
        if ((k == 0 ? exp0.size() : exp1.size()) == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result%0d: got %0h expected none", k, acc_out[k]);
        end else begin
          e = (k == 0) ? exp0.pop_front() : exp1.pop_front();
          chk($sformatf("acc_out%0d", k), int'(acc_out[k]), int'(e[15:0]));
          chk($sformatf("ovf%0d", k), int'(ovf[k]), int'(e[16]));
        end
      end
      pv[k] = rst_n && out_valid[k] && !out_ready;
      pa[k] = acc_out[k];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string name);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_in_ready%0d", name, k), int'(in_ready[k]), 0);
      chk($sformatf("%s_out_valid%0d", name, k), int'(out_valid[k]), 0);
      chk($sformatf("%s_ovf%0d", name, k), int'(ovf[k]), 0);
      chk($sformatf("%s_busy%0d", name, k), int'(busy[k]), 0);
      chk($sformatf("%s_acc_out%0d", name, k), int'(acc_out[k]), 0);
    end
  endtask

  task automatic run(input int n, input bit gaps, input bit poke, input int hold);
    exp0.push_back(model(1'b0));
    exp1.push_back(model(1'b1));
    start = 1;
    len = 8'(n);
    tick();
    start = 0;
    chk("busy_after_start", int'(busy[0]), 1);
    for (int i = 0; i < n; i++) begin
      int g = gaps ? int'($urandom_range(3, 0)) : 0;
      repeat (g) begin
        chk("ready_in_gap", int'(in_ready[0]), 1);
        start = poke;
        len = 8'($urandom);
        tick();
        start = 0;
      end
      chk("in_ready_acc", int'(in_ready[1]), 1);
      in_valid = 1;
      in_data = d_q[i];
      in_sub = s_q[i];
      tick();
      in_valid = 0;
    end
    chk("in_ready_done", int'(in_ready[0]), 0);
    chk("out_valid_latency0", int'(out_valid[0]), 1);
    chk("out_valid_latency1", int'(out_valid[1]), 1);
    repeat (hold) begin
      tick();
      chk("in_ready_hold", int'(in_ready[0]), 0);
    end
    out_ready = 1;
    start = poke;
    tick();
    out_ready = 0;
    start = 0;
    chk("out_valid_drop", int'(out_valid[0]), 0);
    chk("idle_after_pop", int'(busy[1]), 0);
  endtask

  initial begin
    #12;
    chk_zero("reset_low");
    tick();
    rst_n = 1;
    tick();
    chk_zero("reset_idle");
    d_q = '{16'd5, 16'd7, 16'd2};
    s_q = '{0, 0, 1};
    run(3, 0, 0, 1);
    d_q = '{16'h7FFF, 16'h0001};
    s_q = '{0, 0};
    run(2, 0, 0, 0);
    d_q = '{16'h8000, 16'h0001};
    s_q = '{0, 1};
    run(2, 0, 0, 2);
    d_q = {};
    s_q = {};
    run(0, 0, 0, 4);
    d_q = '{16'd1, 16'd1, 16'd1, 16'd1};
    s_q = '{0, 0, 0, 0};
    run(4, 1, 1, 1);
    start = 1;
    len = 8'd4;
    tick();
    start = 0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1;
      in_data = 16'h7FFF;
      in_sub = 0;
      tick();
    end
    in_valid = 0;
    chk("ovf_before_reset", int'(ovf[0]), 1);
    chk("acc_out_before_reset", int'(acc_out[0]), 4);
    @(posedge clk);
    #3 rst_n = 0;
    #1 chk_zero("async_reset");
    tick();
    rst_n = 1;
    tick();
    d_q = '{16'd9};
    s_q = '{0};
    run(1, 0, 0, 0);
    for (int t = 0; t < 40; t++) begin
      int n = $urandom_range(12, 0);
      d_q = {};
      s_q = {};
      for (int i = 0; i < n; i++) begin
        int sel = $urandom_range(3, 0);
        d_q.push_back(sel == 0 ? 16'h7FFF : sel == 1 ? 16'h8000 : 16'($urandom));
        s_q.push_back(1'($urandom));
      end
      run(n, 1'($urandom), 1'($urandom), $urandom_range(3, 0));
    end
    d_q = {};
    s_q = {};
    for (int i = 0; i < 255; i++) begin
      d_q.push_back(16'($urandom_range(300, 0)));
      s_q.push_back(1'b0);
    end
    run(255, 0, 1, 1);
    repeat (3) tick();
    chk("drain0", exp0.size(), 0);
    chk("drain1", exp1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_accum_seq.md
Name: mac_accum_seq

Overview:
- Sequencer and accumulator stage sitting directly downstream of the 16-bit carry-select add/sub in the reconfigurable MAC datapath.
- Consumes a stream of 16-bit signed operands over a valid/ready handshake and adds or subtracts each one into a running 16-bit accumulator.
- After a programmed number of beats, presents the result on an output valid/ready port.
- Provides wrap or saturate overflow handling and a sticky overflow flag.

Parameters:
- W, 16, data and accumulator width (two's complement).
- LEN_W, 8, width of the beat-count field.
- SAT, 0, 1 = saturate on signed overflow; 0 = wrap modulo 2^W.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a new accumulation run.
- len  input  LEN_W  number of beats in the run; sampled when start is accepted.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand.
- in_data  input  W  signed operand.
- in_sub  input  1  1 = acc - in_data, 0 = acc + in_data; sampled per beat.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- acc_out  output  W  accumulated result.
- ovf  output  1  sticky: at least one beat in the current run overflowed.
- busy  output  1  high in the ACC or DONE state.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; acc=0; count=0.
  - in_ready=0, out_valid=0, ovf=0, busy=0.
  - acc_out=0.
- All outputs are registered or decoded from state. No combinational path from in_valid to in_ready.
- States:
  - IDLE:
    - in_ready=0.
    - start=1 with len≠0 -> ACC. Clears acc and ovf, loads count=len.
    - start=1 with len=0 -> DONE. acc=0, ovf=0.
  - ACC:
    - in_ready=1.
    - A beat is in_valid & in_ready. On a beat: acc <= f(acc, in_data, in_sub); count decrements.
    - On the beat where count==1 -> DONE.
    - Cycles without in_valid hold all state.
  - DONE:
    - out_valid=1, acc_out=acc. Both are held stable until out_ready=1.
    - When out_valid & out_ready -> IDLE. out_valid drops the next cycle.
    - acc_out keeps its last value in IDLE.
- Latency: out_valid rises on the cycle after the final beat is accepted.
  - Minimum run length for len=1: start (cycle 0), beat (cycle 1), out_valid (cycle 2).
- start while busy=1 is ignored. There is no restart and no abort.
- Arithmetic:
  - Full W-bit two's complement.
  - Add overflow: operands have the same sign and the result sign differs.
  - Sub overflow: operand signs differ and the result sign differs from acc.
  - On overflow: ovf <= 1 (sticky until the next accepted start).
    - SAT=0: result wraps.
    - SAT=1: result is clamped to 2^(W-1)-1 for positive overflow, -2^(W-1) for negative.
  - After a clamp, accumulation continues from the clamped value.
- Count: LEN_W bits. len is interpreted unsigned, so len=255 gives 255 beats.
- Reset mid-run: immediately returns to IDLE with all outputs at their reset values. Partial results are lost.
- Simultaneous out_ready and start in DONE: start is ignored, because busy is still 1 in that cycle.

Test Plan:
- Reset, then start len=3. Beats +5, +7, -2 (in_sub=1 on the third beat, data=2) -> out_valid one cycle after the third beat, acc_out=0x000A, ovf=0.
- SAT=0: len=2, beats +0x7FFF, +0x0001 -> acc_out=0x8000, ovf=1. Repeat with SAT=1 -> acc_out=0x7FFF, ovf=1.
- SAT=1: len=2, beats -0x8000 (in_data=0x8000, in_sub=0), then in_sub=1 with data 0x0001 -> acc_out=0x8000, ovf=1.
- len=0 start -> DONE on the next cycle, acc_out=0, in_ready never asserted. Hold out_ready=0 for 4 cycles -> out_valid and acc_out stable. Then out_ready=1 -> IDLE.
- len=4 with in_valid gaps of 0–3 cycles between beats of +1 -> acc_out=4. A start pulse issued mid-run is ignored and the result is unchanged.
- Assert rst_n=0 asynchronously after 2 of 4 beats -> outputs go to 0 immediately, without waiting for a clock edge. A new start len=1 with beat +9 -> acc_out=9, ovf=0.
